// File: rtl/nbhd_pkg.sv
// Shared constants for the 3x3 neighbourhood window generator.
// - FSM state encoding (IDLE, RUN, DONE)
// - border-mode selectors for the MODE parameter
// - cell indices of the row-major 3x3 window (0 = top-left, 4 = centre, 8 = bottom-right)
package nbhd_pkg;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  localparam int unsigned ModeValid = 0;
  localparam int unsigned ModeZero  = 1;

  localparam int unsigned CellTl   = 0;
  localparam int unsigned CellTc   = 1;
  localparam int unsigned CellTr   = 2;
  localparam int unsigned CellMl   = 3;
  localparam int unsigned CellC    = 4;
  localparam int unsigned CellMr   = 5;
  localparam int unsigned CellBl   = 6;
  localparam int unsigned CellBc   = 7;
  localparam int unsigned CellBr   = 8;
  localparam int unsigned NumCells = 9;

endpackage

// File: rtl/nbhd_line_buf.sv
// Single-port line delay RAM: one combinational read and one write of the same address per
// enabled cycle. The read returns the value stored before this cycle's write, so the entry at
// a given column delays the pixel stream by exactly one scan line.
// Ports:
//   clk_i    - clock
//   en_i     - write enable (one per beat)
//   addr_i   - column address
//   wdata_i  - value to store
//   rdata_o  - value previously stored at addr_i
// Contents are not reset; the window generator masks anything read before it was written.
module nbhd_line_buf #(
  parameter int unsigned Depth = 8,
  parameter int unsigned Width = 8,
  localparam int unsigned Aw   = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic             clk_i,
  input  logic             en_i,
  input  logic [Aw-1:0]    addr_i,
  input  logic [Width-1:0] wdata_i,
  output logic [Width-1:0] rdata_o
);

  logic [Width-1:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/nbhd_window_gen.sv
// Streaming 3x3 neighbourhood window generator.
// Consumes a raster-order pixel stream (valid/ready), keeps two previous lines in line buffers
// and a 3-column shift register, and emits one 3x3 window per output beat through a one-entry
// output register. MODE 0 (VALID) emits interior windows only; MODE 1 (ZERO) emits one
// zero-padded window per pixel, using bubble positions past the right/bottom edge.
// Ports:
//   mainClk, mainRstN     - clock, async active-low reset
//   start                 - arms a frame (sampled in IDLE only)
//   pixIn/pixValid/pixReady - input pixel stream
//   winOut/winValid/winReady - output window stream, cell k at bits k*DATA_W +: DATA_W
//   busy                  - high while a frame is running
//   frameDone             - one-cycle pulse after the last window is accepted
module nbhd_window_gen #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned IMG_W  = 256,
  parameter int unsigned IMG_H  = 256,
  parameter int unsigned MODE   = 0
) (
  input  logic                mainClk,
  input  logic                mainRstN,
  input  logic                start,
  input  logic [DATA_W-1:0]   pixIn,
  input  logic                pixValid,
  output logic                pixReady,
  output logic [9*DATA_W-1:0] winOut,
  output logic                winValid,
  input  logic                winReady,
  output logic                busy,
  output logic                frameDone
);
  import nbhd_pkg::*;

  localparam bit          ZeroMode = (MODE == ModeZero);
  // Scan space: ZERO mode adds one bubble column and one bubble row.
  localparam int unsigned SW       = ZeroMode ? IMG_W + 1 : IMG_W;
  localparam int unsigned SH       = ZeroMode ? IMG_H + 1 : IMG_H;
  localparam int unsigned CW       = $clog2(IMG_W + 2);
  localparam int unsigned RW       = $clog2(IMG_H + 2);
  localparam int unsigned LbAw     = (SW > 1) ? $clog2(SW) : 1;

  typedef logic [NumCells-1:0][DATA_W-1:0] win_t;

  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     vcol_q, vcol_d;
  logic [RW-1:0]     vrow_q, vrow_d;
  logic              scan_done_q, scan_done_d;
  win_t              win_q, win_d;
  win_t              out_q, out_d;
  logic              win_valid_q, win_valid_d;

  logic              run, bubble, slot_free, beat, emit, load;
  logic [DATA_W-1:0] pix_eff, lb0_rdata, lb1_rdata;
  logic [LbAw-1:0]   lb_addr;
  logic [2:0][DATA_W-1:0] new_col;
  win_t              win_shift, win_masked;

  assign run       = (state_q == StRun);
  assign bubble    = ZeroMode && ((vcol_q == CW'(IMG_W)) || (vrow_q == RW'(IMG_H)));
  assign slot_free = !win_valid_q || winReady;
  // scan_done_q holds the input closed between the last beat and its window's handshake.
  assign pixReady  = run && !scan_done_q && !bubble && slot_free;
  assign beat      = run && !scan_done_q && slot_free && (bubble || pixValid);
  assign pix_eff   = bubble ? '0 : pixIn;
  assign lb_addr   = vcol_q[LbAw-1:0];

  nbhd_line_buf #(
    .Depth (SW),
    .Width (DATA_W)
  ) u_line_buf0 (
    .clk_i   (mainClk),
    .en_i    (beat),
    .addr_i  (lb_addr),
    .wdata_i (pix_eff),
    .rdata_o (lb0_rdata)
  );

  // Second line buffer takes the line the first one is retiring.
  nbhd_line_buf #(
    .Depth (SW),
    .Width (DATA_W)
  ) u_line_buf1 (
    .clk_i   (mainClk),
    .en_i    (beat),
    .addr_i  (lb_addr),
    .wdata_i (lb0_rdata),
    .rdata_o (lb1_rdata)
  );

  assign new_col[0] = lb1_rdata;
  assign new_col[1] = lb0_rdata;
  assign new_col[2] = pix_eff;

  always_comb begin
    win_shift = win_q;
    for (int r = 0; r < 3; r++) begin
      win_shift[3*r]     = win_q[3*r+1];
      win_shift[3*r + 1] = win_q[3*r+2];
      win_shift[3*r + 2] = new_col[r];
    end
    // Top and left zeros are forced here; bottom and right zeros arrive through bubbles.
    win_masked = win_shift;
    if (ZeroMode && (vrow_q == RW'(1))) begin
      win_masked[CellTl] = '0;
      win_masked[CellTc] = '0;
      win_masked[CellTr] = '0;
    end
    if (ZeroMode && (vcol_q == CW'(1))) begin
      win_masked[CellTl] = '0;
      win_masked[CellMl] = '0;
      win_masked[CellBl] = '0;
    end
  end

  always_comb begin
    if (ZeroMode) begin
      emit = (vrow_q >= RW'(1)) && (vcol_q >= CW'(1));
    end else begin
      emit = (vrow_q >= RW'(2)) && (vcol_q >= CW'(2));
    end
  end

  assign load = beat && emit;

  always_comb begin
    state_d     = state_q;
    vcol_d      = vcol_q;
    vrow_d      = vrow_q;
    scan_done_d = scan_done_q;
    win_d       = win_q;

    case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (scan_done_q && win_valid_q && winReady) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (!run) begin
      vcol_d      = '0;
      vrow_d      = '0;
      scan_done_d = 1'b0;
      win_d       = '0;
    end else if (beat) begin
      win_d = win_shift;
      if (vcol_q == CW'(SW - 1)) begin
        vcol_d = '0;
        if (vrow_q == RW'(SH - 1)) begin
          scan_done_d = 1'b1;
        end else begin
          vrow_d = vrow_q + RW'(1);
        end
      end else begin
        vcol_d = vcol_q + CW'(1);
      end
    end
  end

  always_comb begin
    out_d = load ? win_masked : out_q;
    if (load) begin
      win_valid_d = 1'b1;
    end else if (winReady) begin
      win_valid_d = 1'b0;
    end else begin
      win_valid_d = win_valid_q;
    end
  end

  always_ff @(posedge mainClk or negedge mainRstN) begin
    if (!mainRstN) begin
      state_q     <= StIdle;
      vcol_q      <= '0;
      vrow_q      <= '0;
      scan_done_q <= 1'b0;
      win_q       <= '0;
      out_q       <= '0;
      win_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      vcol_q      <= vcol_d;
      vrow_q      <= vrow_d;
      scan_done_q <= scan_done_d;
      win_q       <= win_d;
      out_q       <= out_d;
      win_valid_q <= win_valid_d;
    end
  end

  assign winOut    = out_q;
  assign winValid  = win_valid_q;
  assign busy      = run;
  assign frameDone = (state_q == StDone);

endmodule

// File: tb/tb_nbhd_window_gen.sv
module tb_nbhd_window_gen;
  localparam int DW = 8;
  localparam int IW = 5;
  localparam int IH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_v = 1'b0;
  logic start_z = 1'b0;
  logic [DW-1:0] pix_in = '0;
  logic pix_valid = 1'b0;
  logic win_ready = 1'b1;

  logic pix_ready_v, win_valid_v, busy_v, frame_done_v;
  logic pix_ready_z, win_valid_z, busy_z, frame_done_z;
  logic [9*DW-1:0] win_out_v, win_out_z;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  nbhd_window_gen #(.DATA_W(DW), .IMG_W(IW), .IMG_H(IH), .MODE(0)) u_dut_v (
    .mainClk(clk), .mainRstN(rst_n), .start(start_v), .pixIn(pix_in), .pixValid(pix_valid),
    .pixReady(pix_ready_v), .winOut(win_out_v), .winValid(win_valid_v), .winReady(win_ready),
    .busy(busy_v), .frameDone(frame_done_v)
  );

  nbhd_window_gen #(.DATA_W(DW), .IMG_W(IW), .IMG_H(IH), .MODE(1)) u_dut_z (
    .mainClk(clk), .mainRstN(rst_n), .start(start_z), .pixIn(pix_in), .pixValid(pix_valid),
    .pixReady(pix_ready_z), .winOut(win_out_z), .winValid(win_valid_z), .winReady(win_ready),
    .busy(busy_z), .frameDone(frame_done_z)
  );

  // Observation of whichever instance is under test.
  bit sel_zero = 1'b0;
  logic pr, wv, bz, fd;
  logic [9*DW-1:0] wo;
  assign pr = sel_zero ? pix_ready_z : pix_ready_v;
  assign wv = sel_zero ? win_valid_z : win_valid_v;
  assign bz = sel_zero ? busy_z : busy_v;
  assign fd = sel_zero ? frame_done_z : frame_done_v;
  assign wo = sel_zero ? win_out_z : win_out_v;

  logic [9*DW-1:0] cap[$];
  int done_cnt, done_at, acc_cnt, fw_acc, low_cnt, tot_pix;

  always @(negedge clk) begin
    if (wv && win_ready) cap.push_back(wo);
    if (wv && fw_acc < 0) fw_acc = acc_cnt;
    if (bz && !pr && acc_cnt >= 1 && acc_cnt < tot_pix) low_cnt++;
    if (pr && pix_valid) acc_cnt++;
    if (fd) begin
      done_cnt++;
      done_at = cap.size();
    end
  end

  task automatic clear_mon(input int tp);
    cap.delete();
    done_cnt = 0;
    done_at = -1;
    acc_cnt = 0;
    fw_acc = -1;
    low_cnt = 0;
    tot_pix = tp;
  endtask

  // Expected window n straight from the image definition pixel(r,c) = r*16+c.
  function automatic logic [9*DW-1:0] ref_win(input bit zero, input int n);
    int cr, cc, r, c;
    logic [9*DW-1:0] w;
    w = '0;
    if (zero) begin
      cr = n / IW;
      cc = n % IW;
    end else begin
      cr = n / (IW - 2) + 1;
      cc = n % (IW - 2) + 1;
    end
    for (int k = 0; k < 9; k++) begin
      r = cr + k / 3 - 1;
      c = cc + k % 3 - 1;
      if (r >= 0 && r < IH && c >= 0 && c < IW) w[k*DW +: DW] = DW'(r * 16 + c);
    end
    return w;
  endfunction

  function automatic int list_errs(input bit zero);
    int n, e;
    n = zero ? IW * IH : (IW - 2) * (IH - 2);
    e = (cap.size() != n) ? 1 : 0;
    for (int i = 0; i < cap.size() && i < n; i++) begin
      if (cap[i] !== ref_win(zero, i)) e++;
    end
    return e;
  endfunction

  task automatic run_frame(input bit zero, input int pv_pct, input int wr_pct,
                           input bit hold_start, input int stall_at, input int stall_len,
                           output int stall_acc, output int stall_bad);
    int idx, cyc, st_left;
    bit stalled;
    logic [9*DW-1:0] snap;
    sel_zero = zero;
    clear_mon(IW * IH);
    @(posedge clk); #1;
    if (zero) start_z = 1'b1; else start_v = 1'b1;
    @(posedge clk); #1;
    if (!hold_start) begin
      start_v = 1'b0;
      start_z = 1'b0;
    end
    idx = 0; cyc = 0; st_left = 0; stalled = 1'b0; snap = '0;
    stall_acc = 0; stall_bad = 0;
    while (done_cnt == 0 && cyc < 3000) begin
      pix_valid = (idx < IW * IH) && (int'($urandom_range(0, 99)) < pv_pct);
      pix_in = DW'((idx / IW) * 16 + idx % IW);
      if (stall_at >= 0 && !stalled && cap.size() >= stall_at && wv) begin
        stalled = 1'b1;
        st_left = stall_len;
      end
      if (st_left > 0) win_ready = 1'b0;
      else win_ready = (int'($urandom_range(0, 99)) < wr_pct);
      @(negedge clk);
      if (st_left > 0) begin
        if (st_left == stall_len) snap = wo;
        else if (wo !== snap || !wv) stall_bad++;
        if (pix_valid && pr) stall_acc++;
        st_left--;
      end
      if (pix_valid && pr) idx++;
      @(posedge clk); #1;
      cyc++;
    end
    start_v = 1'b0;
    start_z = 1'b0;
    pix_valid = 1'b0;
    win_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #3;
    total++;
    if ({pix_ready_v, win_valid_v, busy_v, frame_done_v,
         pix_ready_z, win_valid_z, busy_z, frame_done_z} !== 8'h00) begin
      bad++;
      $display("FAIL reset_ctrl: got %b want 00000000", {pix_ready_v, win_valid_v, busy_v,
               frame_done_v, pix_ready_z, win_valid_z, busy_z, frame_done_z});
    end
    total++;
    if ({win_out_v, win_out_z} !== '0) begin
      bad++;
      $display("FAIL reset_winout: got %h / %h want 0", win_out_v, win_out_z);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({pix_ready_v, busy_v, pix_ready_z, busy_z} !== 4'h0) begin
      bad++;
      $display("FAIL idle_after_reset: got %b want 0000",
               {pix_ready_v, busy_v, pix_ready_z, busy_z});
    end
  endtask

  task automatic test_valid_stream();
    int sa, sb, e;
    logic [9*DW-1:0] w;
    run_frame(1'b0, 100, 100, 1'b0, -1, 0, sa, sb);
    total++;
    if (cap.size() !== 6) begin
      bad++;
      $display("FAIL valid_count: got %0d want 6", cap.size());
    end
    w = (cap.size() > 0) ? cap[0] : '1;
    total++;
    if ({w[8*DW +: DW], w[4*DW +: DW], w[0 +: DW]} !== 24'h22_11_00) begin
      bad++;
      $display("FAIL valid_first: got %h want 221100", {w[8*DW +: DW], w[4*DW +: DW], w[0 +: DW]});
    end
    w = (cap.size() > 0) ? cap[cap.size()-1] : '1;
    total++;
    if ({w[8*DW +: DW], w[4*DW +: DW], w[0 +: DW]} !== 24'h34_23_12) begin
      bad++;
      $display("FAIL valid_last: got %h want 342312", {w[8*DW +: DW], w[4*DW +: DW], w[0 +: DW]});
    end
    e = list_errs(1'b0);
    total++;
    if (e !== 0) begin
      bad++;
      $display("FAIL valid_list: got %0d bad windows want 0", e);
    end
    total++;
    if (done_cnt !== 1 || done_at !== 6) begin
      bad++;
      $display("FAIL valid_done: got pulses=%0d at=%0d want 1 at 6", done_cnt, done_at);
    end
    total++;
    if (fw_acc !== 13) begin
      bad++;
      $display("FAIL valid_latency: got %0d pixels want 13", fw_acc);
    end
  endtask

  task automatic test_zero_stream();
    int sa, sb, e;
    logic [9*DW-1:0] w;
    run_frame(1'b1, 100, 100, 1'b0, -1, 0, sa, sb);
    total++;
    if (cap.size() !== 20) begin
      bad++;
      $display("FAIL zero_count: got %0d want 20", cap.size());
    end
    w = (cap.size() > 0) ? cap[0] : '1;
    total++;
    if (w !== {8'h11, 8'h10, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}) begin
      bad++;
      $display("FAIL zero_first: got %h want 111000010000000000", w);
    end
    w = (cap.size() > 0) ? cap[cap.size()-1] : '1;
    total++;
    if (w !== {8'h00, 8'h00, 8'h00, 8'h00, 8'h34, 8'h33, 8'h00, 8'h24, 8'h23}) begin
      bad++;
      $display("FAIL zero_last: got %h want 000000003433002423", w);
    end
    e = list_errs(1'b1);
    total++;
    if (e !== 0) begin
      bad++;
      $display("FAIL zero_list: got %0d bad windows want 0", e);
    end
    total++;
    if (done_cnt !== 1 || done_at !== 20) begin
      bad++;
      $display("FAIL zero_done: got pulses=%0d at=%0d want 1 at 20", done_cnt, done_at);
    end
    total++;
    if (fw_acc !== 7) begin
      bad++;
      $display("FAIL zero_latency: got %0d pixels want 7", fw_acc);
    end
    total++;
    if (low_cnt !== 3) begin
      bad++;
      $display("FAIL zero_row_bubbles: got %0d low cycles want 3", low_cnt);
    end
  endtask

  task automatic test_backpressure();
    int sa, sb, e;
    run_frame(1'b0, 100, 100, 1'b0, 1, 10, sa, sb);
    total++;
    if (sa > 1) begin
      bad++;
      $display("FAIL bp_accepts: got %0d pixels during stall want <=1", sa);
    end
    total++;
    if (sb !== 0) begin
      bad++;
      $display("FAIL bp_hold: got %0d unstable cycles want 0", sb);
    end
    e = list_errs(1'b0);
    total++;
    if (e !== 0) begin
      bad++;
      $display("FAIL bp_list: got %0d bad windows want 0", e);
    end
    total++;
    if (done_cnt !== 1) begin
      bad++;
      $display("FAIL bp_done: got %0d pulses want 1", done_cnt);
    end
  endtask

  task automatic test_random();
    int sa, sb, e;
    for (int z = 0; z < 2; z++) begin
      run_frame(z[0], 60, 50, 1'b0, -1, 0, sa, sb);
      e = list_errs(z[0]);
      total++;
      if (e !== 0) begin
        bad++;
        $display("FAIL rand_list mode=%0d: got %0d bad windows want 0", z, e);
      end
      total++;
      if (done_cnt !== 1) begin
        bad++;
        $display("FAIL rand_done mode=%0d: got %0d pulses want 1", z, done_cnt);
      end
    end
  endtask

  task automatic test_reset_midframe();
    int idx, cyc, sa, sb, e;
    sel_zero = 1'b1;
    clear_mon(IW * IH);
    @(posedge clk); #1;
    start_z = 1'b1;
    @(posedge clk); #1;
    start_z = 1'b0;
    idx = 0;
    cyc = 0;
    while (idx < 7 && cyc < 100) begin
      pix_valid = 1'b1;
      pix_in = DW'((idx / IW) * 16 + idx % IW);
      win_ready = 1'b1;
      @(negedge clk);
      if (pr) idx++;
      @(posedge clk); #1;
      cyc++;
    end
    pix_valid = 1'b0;
    win_ready = 1'b0;
    @(negedge clk);
    total++;
    if (win_valid_z !== 1'b1) begin
      bad++;
      $display("FAIL mid_window_present: got %b want 1", win_valid_z);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({pix_ready_z, win_valid_z, busy_z, frame_done_z} !== 4'h0 || win_out_z !== '0) begin
      bad++;
      $display("FAIL mid_reset: got ctrl=%b win=%h want 0000 / 0",
               {pix_ready_z, win_valid_z, busy_z, frame_done_z}, win_out_z);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    win_ready = 1'b1;
    pix_valid = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    pix_valid = 1'b0;
    total++;
    if (done_cnt !== 0 || busy_z !== 1'b0) begin
      bad++;
      $display("FAIL mid_no_done: got pulses=%0d busy=%b want 0 / 0", done_cnt, busy_z);
    end
    run_frame(1'b1, 100, 100, 1'b0, -1, 0, sa, sb);
    e = list_errs(1'b1);
    total++;
    if (e !== 0 || done_cnt !== 1) begin
      bad++;
      $display("FAIL mid_restart: got %0d bad windows, %0d pulses want 0 / 1", e, done_cnt);
    end
  endtask

  task automatic test_start_held();
    int sa, sb, e;
    run_frame(1'b0, 100, 100, 1'b1, -1, 0, sa, sb);
    e = list_errs(1'b0);
    total++;
    if (e !== 0) begin
      bad++;
      $display("FAIL start_held_list: got %0d bad windows want 0", e);
    end
    total++;
    if (done_cnt !== 1) begin
      bad++;
      $display("FAIL start_held_done: got %0d pulses want 1", done_cnt);
    end
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (busy_v !== 1'b0) begin
      bad++;
      $display("FAIL start_held_idle: got busy=%b want 0", busy_v);
    end
  endtask

  initial begin
    void'($urandom(32'd20240611));
    test_reset();
    test_valid_stream();
    test_zero_stream();
    test_backpressure();
    test_random();
    test_reset_midframe();
    test_start_held();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
